sprite_fetch_sched: RTL and testbench

//  Per-scanline sprite scheduler for the PPU's 40 sprite slots. On line_start it scans OAM
//  one slot per clock and keeps up to SPR_PER_LINE vertically visible sprites, in index order.
//  It then fetches the two tile-data bytes of each kept sprite over a shared VRAM read port,

---
 rtl/sprite_fetch_sched_pkg.sv | 46 ++++
 rtl/sprite_fetch_sched_if.sv | 20 ++
 rtl/sprite_fetch_sched_line_list.sv | 60 ++++++
 rtl/sprite_fetch_sched.sv | 171 +++++++++++++++++
 tb/tb_sprite_fetch_sched.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_fetch_sched_pkg.sv
// ============================================================================
//  Module  : sprite_fetch_sched_pkg
//  Brief   : Shared constants, FSM encodings and visibility test for the
//            per-line sprite fetch scheduler.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

package sprite_fetch_sched_pkg;

    localparam int c_OAM_COUNT    = 40;
    localparam int c_SPR_PER_LINE = 10;
    localparam int c_RD_LAT       = 2;

    localparam int c_IDX_W     = 6;
    localparam int c_LIST_W    = 4;
    localparam int c_VRAM_AW   = 12;

    localparam logic [8:0] c_SPR_H8    = 9'd8;
    localparam logic [8:0] c_SPR_H16   = 9'd16;
    localparam logic [8:0] c_Y_OFFSET  = 9'd16;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_SCAN     = 3'd1;
    localparam logic [2:0] c_ST_FETCH_LO = 3'd2;
    localparam logic [2:0] c_ST_WAIT_LO  = 3'd3;
    localparam logic [2:0] c_ST_FETCH_HI = 3'd4;
    localparam logic [2:0] c_ST_WAIT_HI  = 3'd5;
    localparam logic [2:0] c_ST_DONE     = 3'd6;

    // 9-bit compare so sprites parked near the bottom of OAM space never wrap
    function automatic logic spr_visible(input logic [7:0] v_cnt,
                                         input logic [7:0] y_pos,
                                         input logic       size16);
        logic [8:0] line;
        logic [8:0] top;
        logic [8:0] h;
        line = {1'b0, v_cnt} + c_Y_OFFSET;
        top  = {1'b0, y_pos};
        h    = size16 ? c_SPR_H16 : c_SPR_H8;
        return (line >= top) && (line < top + h);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sprite_fetch_sched_if.sv
// ============================================================================
//  Module  : sprite_fetch_sched_if
//  Brief   : Shared VRAM read port (req/gnt handshake plus address).
//  Rev     : 1.0
// ============================================================================
`default_nettype none

interface sprite_fetch_sched_if;
    import sprite_fetch_sched_pkg::*;

    logic                 vram_req;
    logic                 vram_gnt;
    logic [c_VRAM_AW-1:0] vram_addr;

    modport master (output vram_req, output vram_addr, input vram_gnt);
    modport slave  (input vram_req, input vram_addr, output vram_gnt);

endinterface

`default_nettype wire

// File: rtl/sprite_fetch_sched_line_list.sv
// ============================================================================
//  Module  : sprite_line_list
//  Brief   : In-order list of kept sprite slot indices with clear, saturating
//            append, count and random read.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module sprite_line_list
    import sprite_fetch_sched_pkg::*;
#(
    parameter int DEPTH = c_SPR_PER_LINE
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                i_clear,
    input  wire logic                i_append,
    input  wire logic [c_IDX_W-1:0]  i_app_idx,
    input  wire logic [c_LIST_W-1:0] i_rd_idx,
    output logic      [c_IDX_W-1:0]  o_rd_data,
    output logic      [c_LIST_W-1:0] o_count
);

    logic [c_IDX_W-1:0]  r_list [DEPTH];
    logic [c_LIST_W-1:0] r_count;
    logic                w_room;

    assign w_room  = r_count < c_LIST_W'(DEPTH);
    assign o_count = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_list[i] <= '0;
            end
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_append && w_room) begin
            r_count <= r_count + c_LIST_W'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (r_count == c_LIST_W'(i)) begin
                    r_list[i] <= i_app_idx;
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (i_rd_idx == c_LIST_W'(i)) begin
                o_rd_data = r_list[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sprite_fetch_sched.sv
// ============================================================================
//  Module  : sprite_fetch_sched
//  Brief   : Scans OAM once per line for visible sprites, then fetches both
//            tile planes of each kept sprite over the shared VRAM port.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module sprite_fetch_sched
    import sprite_fetch_sched_pkg::*;
#(
    parameter int OAM_COUNT    = c_OAM_COUNT,
    parameter int SPR_PER_LINE = c_SPR_PER_LINE,
    parameter int RD_LAT       = c_RD_LAT
) (
    input  wire logic                clk,
    input  wire logic                reset_n,
    input  wire logic                line_start,
    input  wire logic [7:0]          v_cnt,
    input  wire logic                size16,
    output logic      [c_IDX_W-1:0]  scan_idx,
    input  wire logic [7:0]          oam_y,
    output logic      [c_IDX_W-1:0]  spr_sel,
    input  wire logic [10:0]         spr_addr,
    sprite_fetch_sched_if.master     vram,
    output logic      [1:0]          ds,
    output logic      [c_LIST_W-1:0] spr_count,
    output logic                     busy,
    output logic                     done
);

    localparam int                 c_LAT_W    = $clog2(RD_LAT + 1);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(RD_LAT - 1);

    logic [2:0]          r_state;
    logic [c_IDX_W-1:0]  r_scan_idx;
    logic [c_IDX_W-1:0]  r_spr_sel;
    logic [c_LIST_W-1:0] r_k;
    logic [c_LAT_W-1:0]  r_lat;
    logic                r_req;
    logic [1:0]          r_ds;
    logic                r_busy;
    logic                r_done;

    logic                w_scan;
    logic                w_append;
    logic                w_last_slot;
    logic                w_have_spr;
    logic                w_fetching;
    logic                w_hi;
    logic [c_LIST_W-1:0] w_count;
    logic [c_LIST_W-1:0] w_k_next;
    logic [c_LIST_W-1:0] w_rd_idx;
    logic [c_IDX_W-1:0]  w_rd_data;
    logic [c_IDX_W-1:0]  w_first_sel;

    assign w_scan      = (r_state == c_ST_SCAN);
    assign w_append    = w_scan && spr_visible(v_cnt, oam_y, size16);
    assign w_last_slot = (r_scan_idx == c_IDX_W'(OAM_COUNT - 1));
    assign w_have_spr  = (w_count != '0) || w_append;
    assign w_k_next    = r_k + c_LIST_W'(1);
    assign w_rd_idx    = w_scan ? '0 : w_k_next;
    // The final slot may be the first one kept, before it lands in the list
    assign w_first_sel = (w_count == '0) ? r_scan_idx : w_rd_data;
    assign w_fetching  = (r_state == c_ST_FETCH_LO) || (r_state == c_ST_FETCH_HI);
    assign w_hi        = (r_state == c_ST_FETCH_HI);

    sprite_line_list #(
        .DEPTH     (SPR_PER_LINE)
    ) u_list (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (line_start),
        .i_append  (w_append),
        .i_app_idx (r_scan_idx),
        .i_rd_idx  (w_rd_idx),
        .o_rd_data (w_rd_data),
        .o_count   (w_count)
    );

    assign scan_idx       = r_scan_idx;
    assign spr_sel        = r_spr_sel;
    assign spr_count      = w_count;
    assign ds             = r_ds;
    assign busy           = r_busy;
    assign done           = r_done;
    assign vram.vram_req  = r_req;
    assign vram.vram_addr = w_fetching ? {spr_addr, w_hi} : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_IDLE;
            r_scan_idx <= '0;
            r_spr_sel  <= '0;
            r_k        <= '0;
            r_lat      <= '0;
            r_req      <= 1'b0;
            r_ds       <= 2'b00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (line_start) begin
            r_state    <= c_ST_SCAN;
            r_scan_idx <= '0;
            r_k        <= '0;
            r_lat      <= '0;
            r_req      <= 1'b0;
            r_ds       <= 2'b00;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                c_ST_SCAN: begin
                    if (w_last_slot) begin
                        r_scan_idx <= '0;
                        r_k        <= '0;
                        if (w_have_spr) begin
                            r_state   <= c_ST_FETCH_LO;
                            r_spr_sel <= w_first_sel;
                            r_req     <= 1'b1;
                        end else begin
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_scan_idx <= r_scan_idx + c_IDX_W'(1);
                    end
                end
                c_ST_FETCH_LO, c_ST_FETCH_HI: begin
                    if (r_req && vram.vram_gnt) begin
                        r_req   <= 1'b0;
                        r_lat   <= '0;
                        r_state <= w_hi ? c_ST_WAIT_HI : c_ST_WAIT_LO;
                    end
                end
                c_ST_WAIT_LO, c_ST_WAIT_HI: begin
                    // Strobe cycle is the last cycle of WAIT, so it never overlaps a request
                    if (r_ds != 2'b00) begin
                        r_ds <= 2'b00;
                        if (r_state == c_ST_WAIT_LO) begin
                            r_state <= c_ST_FETCH_HI;
                            r_req   <= 1'b1;
                        end else if (w_k_next == w_count) begin
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_k       <= w_k_next;
                            r_spr_sel <= w_rd_data;
                            r_state   <= c_ST_FETCH_LO;
                            r_req     <= 1'b1;
                        end
                    end else begin
                        r_lat <= r_lat + c_LAT_W'(1);
                        if (r_lat == c_LAT_LAST) begin
                            r_ds <= (r_state == c_ST_WAIT_LO) ? 2'b01 : 2'b10;
                        end
                    end
                end
                c_ST_IDLE, c_ST_DONE: begin
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sprite_fetch_sched.sv
// ============================================================================
//  Module  : tb_sprite_fetch_sched
//  Brief   : Directed scoreboard bench for sprite_fetch_sched.
//  Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_sprite_fetch_sched;

    logic        clk;
    logic        reset_n;
    logic        line_start;
    logic [7:0]  v_cnt;
    logic        size16;
    logic [5:0]  scan_idx;
    logic [7:0]  oam_y;
    logic [5:0]  spr_sel;
    logic [10:0] spr_addr;
    logic [1:0]  ds;
    logic [3:0]  spr_count;
    logic        busy;
    logic        done;

    sprite_fetch_sched_if vif ();

    sprite_fetch_sched dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .line_start (line_start),
        .v_cnt      (v_cnt),
        .size16     (size16),
        .scan_idx   (scan_idx),
        .oam_y      (oam_y),
        .spr_sel    (spr_sel),
        .spr_addr   (spr_addr),
        .vram       (vif),
        .ds         (ds),
        .spr_count  (spr_count),
        .busy       (busy),
        .done       (done)
    );

    logic [7:0]  oam [40];
    logic [11:0] q_addr [$];
    logic [7:0]  q_ds   [$];
    logic [3:0]  q_cnt  [$];
    int          total;
    int          bad;
    int          req_seen;
    logic        prev_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign oam_y    = (scan_idx < 6'd40) ? oam[scan_idx] : 8'd0;
    assign spr_addr = {5'b10101, spr_sel};

    function automatic logic [11:0] ea(input int slot, input bit hi);
        logic [5:0] s;
        s = 6'(slot);
        return {5'b10101, s, hi};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic extra(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s: got %0d expected no event", name, act);
    endtask

    task automatic exp_spr(input int slot);
        logic [5:0] s;
        s = 6'(slot);
        q_addr.push_back(ea(slot, 1'b0));
        q_addr.push_back(ea(slot, 1'b1));
        q_ds.push_back({2'b01, s});
        q_ds.push_back({2'b10, s});
    endtask

    task automatic clear_oam();
        for (int i = 0; i < 40; i++) oam[i] = 8'd0;
    endtask

    task automatic start_line(input logic [7:0] v, input logic s16);
        v_cnt  = v;
        size16 = s16;
        @(negedge clk) line_start = 1'b1;
        @(negedge clk) line_start = 1'b0;
    endtask

    // which: 0=done, 1=vram_req, 2=ds[1]
    task automatic wait_for(input int which, input int budget, output int n);
        n = 0;
        while (n < budget && !((which == 0 && done) || (which == 1 && vif.vram_req) ||
                               (which == 2 && ds[1]))) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_scan_idx"}, scan_idx, 0);
        chk({tag, "_spr_sel"}, spr_sel, 0);
        chk({tag, "_vram_addr"}, vif.vram_addr, 0);
        chk({tag, "_spr_count"}, spr_count, 0);
        chk({tag, "_vram_req"}, vif.vram_req, 0);
        chk({tag, "_ds"}, ds, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, strobe or completion
    initial begin
        logic [7:0] e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset_n) begin
                if (vif.vram_req) req_seen++;
                if (vif.vram_req && vif.vram_gnt) begin
                    if (q_addr.size() == 0) extra("gnt_addr", vif.vram_addr);
                    else chk("gnt_addr", vif.vram_addr, q_addr.pop_front());
                end
                if (ds != 2'b00) begin
                    if (q_ds.size() == 0) extra("ds_strobe", {spr_sel, ds});
                    else begin
                        e = q_ds.pop_front();
                        chk("ds_strobe", ds, e[7:6]);
                        chk("ds_sel", spr_sel, e[5:0]);
                    end
                    if (ds == 2'b11 || vif.vram_req) extra("ds_with_req", {vif.vram_req, ds});
                end
                if (done && !prev_done) begin
                    if (q_cnt.size() == 0) extra("done_count", spr_count);
                    else chk("done_count", spr_count, q_cnt.pop_front());
                end
            end
            prev_done = done;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        total = 0; bad = 0; req_seen = 0;
        reset_n = 1'b0; line_start = 1'b0; v_cnt = 8'd0; size16 = 1'b0;
        vif.vram_gnt = 1'b1;
        clear_oam();
        @(negedge clk);
        chk_reset("rst");
        reset_n = 1'b1;
        @(negedge clk);

        // 1: two sprites, gnt tied high
        oam[3] = 8'd16; oam[7] = 8'd16;
        exp_spr(3); exp_spr(7); q_cnt.push_back(4'd2);
        start_line(8'd0, 1'b0);
        wait_for(1, 200, n); chk("t1_first_req", n, 40);
        wait_for(0, 200, n); chk("t1_fetch_time", n, 16);
        chk("t1_count", spr_count, 2);

        // 2: twelve visible, list saturates at ten
        clear_oam();
        for (int i = 0; i < 12; i++) oam[i] = 8'd20;
        for (int i = 0; i < 10; i++) exp_spr(i);
        q_cnt.push_back(4'd10);
        start_line(8'd10, 1'b1);
        wait_for(1, 200, n); chk("t2_scan_len", n, 40);
        wait_for(0, 300, n); chk("t2_fetch_time", n, 80);
        chk("t2_count", spr_count, 10);

        // 3: visibility boundaries
        clear_oam();
        oam[5] = 8'd151; oam[9] = 8'd159; oam[20] = 8'd152;
        exp_spr(9); exp_spr(20); q_cnt.push_back(4'd2);
        start_line(8'd143, 1'b0);
        wait_for(0, 300, n); chk("t3a_done", n, 56);
        clear_oam();
        oam[2] = 8'd250; oam[30] = 8'd8; oam[31] = 8'd9;
        exp_spr(31); q_cnt.push_back(4'd1);
        start_line(8'd0, 1'b0);
        wait_for(0, 300, n); chk("t3b_done", n, 48);

        // 4: arbiter stalls the high-plane fetch for five clocks
        clear_oam();
        oam[12] = 8'd16;
        exp_spr(12); q_cnt.push_back(4'd1);
        vif.vram_gnt = 1'b0;
        start_line(8'd0, 1'b0);
        wait_for(1, 200, n); chk("t4_req_lo", n, 40);
        vif.vram_gnt = 1'b1;
        @(negedge clk) vif.vram_gnt = 1'b0;
        wait_for(1, 50, n); chk("t4_req_hi", n, 3);
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_req", vif.vram_req, 1);
            chk("t4_hold_addr", vif.vram_addr, ea(12, 1'b1));
            chk("t4_hold_sel", spr_sel, 12);
            @(negedge clk);
        end
        vif.vram_gnt = 1'b1;
        n = 0;
        while (!ds[1] && n < 20) begin
            @(negedge clk);
            n++;
            vif.vram_gnt = 1'b0;
        end
        // ds[1] rises RD_LAT edges after the edge that accepted the grant
        chk("t4_ds_lat", n, 3);
        vif.vram_gnt = 1'b1;
        wait_for(0, 50, n); chk("t4_done", done, 1);

        // 5: line_start during WAIT_LO aborts the strobe
        clear_oam();
        oam[4] = 8'd16;
        q_addr.push_back(ea(4, 1'b0));
        start_line(8'd0, 1'b0);
        wait_for(1, 200, n); chk("t5_req", n, 40);
        clear_oam();
        q_cnt.push_back(4'd0);
        start_line(8'd0, 1'b0);
        chk("t5_scan_idx", scan_idx, 0);
        chk("t5_count", spr_count, 0);
        chk("t5_busy", busy, 1);
        chk("t5_done_low", done, 0);

        // 6: empty line, then reset in the middle of a fetch
        wait_for(0, 200, n);
        req_seen = 0;
        q_cnt.push_back(4'd0);
        start_line(8'd0, 1'b0);
        wait_for(0, 200, n); chk("t6_done_time", n, 40);
        chk("t6_no_req", req_seen, 0);
        oam[33] = 8'd16;
        q_addr.push_back(ea(33, 1'b0));
        start_line(8'd0, 1'b0);
        wait_for(1, 200, n); chk("t6_req", n, 40);
        #2 reset_n = 1'b0;
        #1 chk_reset("t6_async");
        @(negedge clk) reset_n = 1'b1;
        repeat (3) @(negedge clk);

        chk("q_leftover", q_addr.size() + q_ds.size() + q_cnt.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
